// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared helpers for the mul_share_arbiter block.
//   MUL_SHARE_MAX_REQ - widest requester vector the helpers handle
//   rr_pick           - rotating-priority pick, returns a one-hot grant
//   onehot_to_idx     - one-hot grant to binary requester index
package mul_share_pkg;

  localparam int MUL_SHARE_MAX_REQ = 16;
  localparam int MUL_SHARE_IDX_W   = $clog2(MUL_SHARE_MAX_REQ);

  // First set bit of valid, searching ptr, ptr+1, ... wrapping at nreq.
  // ptr must be < nreq; bits at and above nreq are ignored.
  function automatic logic [MUL_SHARE_MAX_REQ-1:0] rr_pick(
    input logic [MUL_SHARE_MAX_REQ-1:0] valid,
    input int unsigned                  ptr,
    input int unsigned                  nreq
  );
    logic [MUL_SHARE_MAX_REQ-1:0] grant;
    logic                         found;
    int unsigned                  idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MUL_SHARE_MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= nreq) idx = idx - nreq;
      if (k < nreq && !found && valid[idx[MUL_SHARE_IDX_W-1:0]]) begin
        grant[idx[MUL_SHARE_IDX_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic logic [MUL_SHARE_IDX_W-1:0] onehot_to_idx(
    input logic [MUL_SHARE_MAX_REQ-1:0] oh
  );
    logic [MUL_SHARE_IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < MUL_SHARE_MAX_REQ; k++)
      if (oh[k]) idx = idx | MUL_SHARE_IDX_W'(k);
    return idx;
  endfunction

endpackage

// File: rtl/mul_share_datapath.sv
// mul_share_datapath: combinational n x n multiply with a 2*n-bit product.
//   a, b      - operands
//   is_signed - 1: two's complement operands, 0: unsigned
//   prod      - full 2*n-bit product
module mul_share_datapath #(
  parameter int n = 8
) (
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic           is_signed,
  output logic [2*n-1:0] prod
);

  logic [2*n-1:0] a_ext, b_ext;

  // Extending both operands to 2*n first makes the truncated unsigned
  // product exact for signed inputs too, including min * min.
  always_comb begin
    a_ext = is_signed ? {{n{a[n-1]}}, a} : {{n{1'b0}}, a};
    b_ext = is_signed ? {{n{b[n-1]}}, b} : {{n{1'b0}}, b};
    prod  = a_ext * b_ext;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: one multiplier shared by n_req requesters.
// Round-robin (or fixed priority) grant of at most one op per cycle into a
// 2-stage pipeline; results leave on one tagged valid/ready stream.
//   clk, rst                       - clock, async active-high reset
//   req_valid/req_ready            - per-requester handshake
//   req_a/req_b                    - packed operands, requester i at [i*n +: n]
//   req_signed                     - per-requester signedness
//   res_valid/res_ready            - result handshake
//   res, res_id, res_signed        - product, issuing requester, signedness
// Build option: define MUL_SHARE_FIXED_PRIO_EN for fixed priority (lowest
// valid index wins, no rotating pointer). n_req must be 2..16.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter  int n     = 8,
  parameter  int n_req = 2,
  localparam int id_w  = $clog2(n_req)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [n_req-1:0]     req_valid,
  output logic [n_req-1:0]     req_ready,
  input  logic [n_req*n-1:0]   req_a,
  input  logic [n_req*n-1:0]   req_b,
  input  logic [n_req-1:0]     req_signed,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*n-1:0]       res,
  output logic [id_w-1:0]      res_id,
  output logic                 res_signed
);

  logic [n_req-1:0][n-1:0] a_arr, b_arr;
  assign a_arr = req_a;
  assign b_arr = req_b;

  logic                         s1_valid_q, s1_valid_d;
  logic [n-1:0]                 s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic                         s1_signed_q, s1_signed_d;
  logic [id_w-1:0]              s1_id_q, s1_id_d;
  logic                         s2_valid_q, s2_valid_d;
  logic [2*n-1:0]               s2_prod_q, s2_prod_d;
  logic [id_w-1:0]              s2_id_q, s2_id_d;
  logic                         s2_signed_q, s2_signed_d;

  logic                         s1_adv, s2_adv, xfer;
  logic [MUL_SHARE_MAX_REQ-1:0] valid_ext, grant_ext;
  logic [id_w-1:0]              sel;
  logic [2*n-1:0]               prod;

`ifndef MUL_SHARE_FIXED_PRIO_EN
  logic [id_w-1:0]              rr_ptr_q, rr_ptr_d;
`endif

  always_comb begin
    s2_adv    = !s2_valid_q || res_ready;
    s1_adv    = !s1_valid_q || s2_adv;
    valid_ext = '0;
    valid_ext[n_req-1:0] = req_valid;
`ifdef MUL_SHARE_FIXED_PRIO_EN
    grant_ext = rr_pick(valid_ext, 0, n_req);
`else
    grant_ext = rr_pick(valid_ext, 32'(rr_ptr_q), n_req);
`endif
    // Ready is held low in reset so nothing looks accepted while flops clear.
    req_ready = (s1_adv && !rst) ? grant_ext[n_req-1:0] : '0;
    xfer      = |(req_valid & req_ready);
    sel       = id_w'(onehot_to_idx(grant_ext));
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_signed_d = s1_signed_q;
    s1_id_d     = s1_id_q;
    if (s1_adv) begin
      s1_valid_d = xfer;
      if (xfer) begin
        s1_a_d      = a_arr[sel];
        s1_b_d      = b_arr[sel];
        s1_signed_d = req_signed[sel];
        s1_id_d     = sel;
      end
    end

    // Stage 2 only loads real ops, so a drained output keeps its last value.
    s2_valid_d  = s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_id_d     = s2_id_q;
    s2_signed_d = s2_signed_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_d   = prod;
        s2_id_d     = s1_id_q;
        s2_signed_d = s1_signed_q;
      end
    end
  end

`ifndef MUL_SHARE_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (sel == id_w'(n_req - 1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_signed_q <= 1'b0;
      s1_id_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_id_q     <= '0;
      s2_signed_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_signed_q <= s1_signed_d;
      s1_id_q     <= s1_id_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_id_q     <= s2_id_d;
      s2_signed_q <= s2_signed_d;
    end
  end

  mul_share_datapath #(.n(n)) u_dp (
    .a         (s1_a_q),
    .b         (s1_b_q),
    .is_signed (s1_signed_q),
    .prod      (prod)
  );

  assign res_valid  = s2_valid_q;
  assign res        = s2_prod_q;
  assign res_id     = s2_id_q;
  assign res_signed = s2_signed_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: vector table, scoreboard-checked streams,
// backpressure, mid-operation reset, and a 3-requester wrap case.
module tb_mul_share_arbiter;
  localparam int N  = 8;
  localparam int NR = 2;

  logic clk, rst;
  logic [NR-1:0]         req_valid, req_ready, req_signed;
  logic [NR-1:0][N-1:0]  req_a, req_b;
  logic                  res_valid, res_ready, res_signed;
  logic [2*N-1:0]        res;
  logic [0:0]            res_id;

  logic [2:0]            v3, rdy3, s3;
  logic [2:0][N-1:0]     a3, b3;
  logic                  rv3, rrdy3, rs3;
  logic [2*N-1:0]        r3;
  logic [1:0]            rid3;

  mul_share_arbiter #(.n(N), .n_req(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
    .res_valid(res_valid), .res_ready(res_ready), .res(res),
    .res_id(res_id), .res_signed(res_signed));

  mul_share_arbiter #(.n(N), .n_req(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3),
    .req_a(a3), .req_b(b3), .req_signed(s3),
    .res_valid(rv3), .res_ready(rrdy3), .res(r3),
    .res_id(rid3), .res_signed(rs3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int id; logic [7:0] a; logic [7:0] b; logic s; logic [15:0] exp; } vec_t;
  typedef struct { logic [15:0] prod; int id; logic s; } exp_t;

  int          n_chk, n_pass, n_res;
  int          pend [NR];
  logic [NR-1:0] acc;
  exp_t        sb [$];
  int          gnt_log [$];
  logic        hold;
  logic [17:0] held;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb_;
    logic [15:0]        ua, ub;
    sa = $signed(a); sb_ = $signed(b);
    ua = {8'h00, a};  ub = {8'h00, b};
    return s ? 16'(sa * sb_) : 16'(ua * ub);
  endfunction

  // Scoreboard monitor: pops on result handshake, pushes on request handshake.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb.delete(); acc = '0; hold = 1'b0;
    end else begin
      if (hold)
        chk({res, res_id, res_signed} == held, "res_stable", 32'({res, res_id, res_signed}), 32'(held));
      if (res_valid) begin
        chk(sb.size() > 0, "res_expected", 32'(sb.size()), 32'd1);
        if (res_ready && sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk(res == e.prod, "sb_prod", 32'(res), 32'(e.prod));
          chk(res_id == 1'(e.id) && res_signed == e.s, "sb_tag", 32'({res_id, res_signed}), 32'({1'(e.id), e.s}));
          n_res++;
        end
      end
      hold = res_valid && !res_ready;
      held = {res, res_id, res_signed};
      chk($countones(req_ready) <= 1, "ready_onehot", 32'(req_ready), 32'd1);
      acc = req_valid & req_ready;
      for (int i = 0; i < NR; i++)
        if (acc[i]) begin
          sb.push_back('{model(req_a[i], req_b[i], req_signed[i]), i, req_signed[i]});
          gnt_log.push_back(i);
        end
    end
  end

  // One cycle of the streaming requesters: a requester presents a fresh
  // random op while it has ops pending, holding each until accepted.
  task automatic step(input logic rdy);
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) pend[i]--;
      if (!req_valid[i] || acc[i]) begin
        if (pend[i] > 0) begin
          req_valid[i]  = 1'b1;
          req_a[i]      = 8'($urandom);
          req_b[i]      = 8'($urandom);
          req_signed[i] = 1'($urandom);
        end else req_valid[i] = 1'b0;
      end
    end
    res_ready = rdy;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; v3 = '0; pend[0] = 0; pend[1] = 0;
    @(negedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tv [8];
    logic [NR-1:0] oh;
    logic [2:0]  eg3 [5];
    int          eid3 [5];
    logic [15:0] p3 [3];
    int          base;

    tv[0] = '{0, 8'hFD, 8'h05, 1'b1, 16'hFFF1};
    tv[1] = '{0, 8'hFD, 8'h05, 1'b0, 16'h04F1};
    tv[2] = '{1, 8'h80, 8'h80, 1'b1, 16'h4000};
    tv[3] = '{1, 8'h80, 8'h80, 1'b0, 16'h4000};
    tv[4] = '{1, 8'hFF, 8'hFF, 1'b1, 16'h0001};
    tv[5] = '{1, 8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tv[6] = '{0, 8'h7F, 8'h80, 1'b1, 16'hC080};
    tv[7] = '{0, 8'h7F, 8'h80, 1'b0, 16'h3F80};

    n_chk = 0; n_pass = 0; n_res = 0; acc = '0; hold = 1'b0; held = '0;
    pend[0] = 0; pend[1] = 0;
    rst = 1'b1; res_ready = 1'b1; rrdy3 = 1'b1;
    req_valid = '1; req_a = '0; req_b = '0; req_signed = '0;
    v3 = '1; a3 = '0; b3 = '0; s3 = '0;

    // Reset state, with requests already pending.
    #12;
    chk(!res_valid && res == 0 && res_id == 0 && !res_signed, "rst_outputs",
        32'({res_valid, res, res_id, res_signed}), 32'd0);
    chk(req_ready == 0, "rst_ready", 32'(req_ready), 32'd0);
    chk(rdy3 == 0 && !rv3, "rst_ready3", 32'({rdy3, rv3}), 32'd0);
    req_valid = '0; v3 = '0;
    @(negedge clk); #2; rst = 1'b0;

    // Vector table: single op, 2-cycle latency, exact product.
    foreach (tv[k]) begin
      @(posedge clk); #1;
      req_valid = '0;
      req_valid[tv[k].id]  = 1'b1;
      req_a[tv[k].id]      = tv[k].a;
      req_b[tv[k].id]      = tv[k].b;
      req_signed[tv[k].id] = tv[k].s;
      oh = '0; oh[tv[k].id] = 1'b1;
      @(negedge clk); #1;
      chk(req_ready == oh, "tv_ready", 32'(req_ready), 32'(oh));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk); #1;
      chk(!res_valid, "tv_early", 32'(res_valid), 32'd0);
      @(negedge clk); #1;
      chk(res_valid, "tv_valid", 32'(res_valid), 32'd1);
      chk(res == tv[k].exp, "tv_res", 32'(res), 32'(tv[k].exp));
      chk(res_id == 1'(tv[k].id) && res_signed == tv[k].s, "tv_tag",
          32'({res_id, res_signed}), 32'({1'(tv[k].id), tv[k].s}));
    end

    // Both requesters streaming with no backpressure.
    do_reset();
    gnt_log.delete();
    pend[0] = 4; pend[1] = 4;
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      if (k >= 2) chk(res_valid, "rr_throughput", 32'(res_valid), 32'd1);
    end
    chk(gnt_log.size() == 8, "rr_count", 32'(gnt_log.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      int e;
`ifdef MUL_SHARE_FIXED_PRIO_EN
      e = (k < 4) ? 0 : 1;
`else
      e = k % 2;
`endif
      chk(k < gnt_log.size() && gnt_log[k] == e, "rr_order", 32'(gnt_log[k]), 32'(e));
    end
    step(1'b1); step(1'b1);

    // Backpressure: two accepts fill the pipe, then ready stays low.
    base = n_res;
    pend[0] = 2; pend[1] = 2;
    step(1'b0); step(1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      chk(req_ready == 0, "bp_ready_low", 32'(req_ready), 32'd0);
      chk(res_valid, "bp_res_valid", 32'(res_valid), 32'd1);
    end
    for (int k = 0; k < 8; k++) step(1'b1);
    chk(n_res - base == 4, "bp_delivered", 32'(n_res - base), 32'd4);
    chk(sb.size() == 0, "bp_drained", 32'(sb.size()), 32'd0);

    // Mid-operation reset: two ops from req0 in flight (pointer left at 1).
    pend[0] = 2;
    step(1'b0); step(1'b0);
    @(posedge clk); #2;
    chk(res_valid, "pre_rst_valid", 32'(res_valid), 32'd1);
    rst = 1'b1; pend[0] = 0; pend[1] = 0; req_valid = '1;
    #1;
    chk(!res_valid, "rst_async_valid", 32'(res_valid), 32'd0);
    chk(req_ready == 0, "rst_async_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #2;
    req_valid = '0; rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      chk(!res_valid, "no_stale", 32'(res_valid), 32'd0);
    end
    pend[0] = 1; pend[1] = 1;
    step(1'b1);
    chk(req_ready == 2'b01, "post_rst_grant", 32'(req_ready), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b1);
    chk(sb.size() == 0, "post_rst_drained", 32'(sb.size()), 32'd0);

    // Three requesters: req1 moves the pointer to 2, then req2/req0 contend.
    do_reset();
    a3[0] = 8'h10; b3[0] = 8'h10; s3[0] = 1'b0;
    a3[1] = 8'h02; b3[1] = 8'h02; s3[1] = 1'b0;
    a3[2] = 8'hF0; b3[2] = 8'h03; s3[2] = 1'b1;
    p3[0] = 16'h0100; p3[1] = 16'h0004; p3[2] = 16'hFFD0;
`ifdef MUL_SHARE_FIXED_PRIO_EN
    eg3[0] = 3'b010; eg3[1] = 3'b001; eg3[2] = 3'b001; eg3[3] = 3'b001; eg3[4] = 3'b001;
    eid3[0] = 1; eid3[1] = 0; eid3[2] = 0; eid3[3] = 0; eid3[4] = 0;
`else
    eg3[0] = 3'b010; eg3[1] = 3'b100; eg3[2] = 3'b001; eg3[3] = 3'b100; eg3[4] = 3'b001;
    eid3[0] = 1; eid3[1] = 2; eid3[2] = 0; eid3[3] = 2; eid3[4] = 0;
`endif
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      v3 = (k == 0) ? 3'b010 : (k <= 4) ? 3'b101 : 3'b000;
      @(negedge clk); #1;
      if (k <= 4) chk(rdy3 == eg3[k], "n3_grant", 32'(rdy3), 32'(eg3[k]));
      if (k >= 2) begin
        chk(rv3 && rid3 == 2'(eid3[k-2]), "n3_res_id", 32'({rv3, rid3}), 32'({1'b1, 2'(eid3[k-2])}));
        chk(r3 == p3[eid3[k-2]], "n3_res", 32'(r3), 32'(p3[eid3[k-2]]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
